// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I load/store funct3 codes, and legality/alignment helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Access size is encoded in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low offset bits so the access lands on its natural boundary.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channels between the execute stage (master) and the
// load/store unit (slave).
interface load_store_unit_if;

  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: extracts and extends load data from a
// memory word, and merges byte/half/word store data into a memory word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  // Little-endian lane select with sign or zero extension by funct3.
  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      // Decide whether this byte lane is overwritten and by which store byte.
      always_comb begin
        hit = 1'b0;
        src = wdata[8*gi +: 8];
        case (funct3[1:0])
          2'b00: begin
            hit = (off == LANE);
            src = wdata[7:0];
          end
          2'b01: begin
            hit = (off[1] == LANE[1]);
            src = LANE[0] ? wdata[15:8] : wdata[7:0];
          end
          2'b10: begin
            hit = 1'b1;
            src = wdata[8*gi +: 8];
          end
          default: hit = 1'b0;
        endcase
      end

      assign merged[8*gi +: 8] = hit ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a word-wide memory with
// combinational reads. Handles sub-word loads (extract + extend) and
// sub-word stores (read-modify-write), one request at a time.
// Optional feature: define LSU_ALIGN_CHECK_EN to report misaligned accesses
// as errors; otherwise misaligned addresses are forced to natural alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_i,
  load_store_unit_if.slave        bus,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic                    mem_we_o,
  input  logic [31:0]             mem_rdata_i
);

  state_t              state_reg, state_next;
  logic [2:0]          f3_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic [31:0]         merged_reg;
  logic [31:0]         rdata_reg;
  logic                err_reg;

  logic                accept;
  logic                acc_err;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         lane_load;
  logic [31:0]         lane_merged;

  assign accept = bus.req_valid_i && (state_reg == ST_IDLE);

`ifdef LSU_ALIGN_CHECK_EN
  assign acc_err  = !f3_legal(bus.req_we_i, bus.req_funct3_i) ||
                    is_misaligned(bus.req_funct3_i, bus.req_addr_i[1:0]);
  assign acc_addr = bus.req_addr_i[ADDR_W-1:0];
`else
  assign acc_err  = !f3_legal(bus.req_we_i, bus.req_funct3_i);
  assign acc_addr = {bus.req_addr_i[ADDR_W-1:2],
                     align_off(bus.req_funct3_i, bus.req_addr_i[1:0])};
`endif

  lsu_lane u_lane (
    .word      (mem_rdata_i),
    .off       (addr_reg[1:0]),
    .funct3    (f3_reg),
    .wdata     (wdata_reg),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: classify the request on accept, then walk the access sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (acc_err)                            state_next = ST_RESP;
          else if (!bus.req_we_i)                 state_next = ST_LOAD;
          else if (bus.req_funct3_i[1:0] == 2'b10) state_next = ST_WRITE;
          else                                    state_next = ST_MERGE;
        end
      end
      ST_LOAD:  state_next = ST_RESP;
      ST_MERGE: state_next = ST_WRITE;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  if (bus.rsp_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request capture, load data sampling and store word merging.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      f3_reg     <= 3'b000;
      addr_reg   <= '0;
      wdata_reg  <= 32'h0;
      merged_reg <= 32'h0;
      rdata_reg  <= 32'h0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            f3_reg     <= bus.req_funct3_i;
            addr_reg   <= acc_addr;
            wdata_reg  <= bus.req_wdata_i;
            merged_reg <= bus.req_wdata_i;
            rdata_reg  <= 32'h0;
            err_reg    <= acc_err;
          end
        end
        ST_LOAD:  rdata_reg  <= lane_load;
        ST_MERGE: merged_reg <= lane_merged;
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o = (state_reg == ST_IDLE);
  assign bus.rsp_valid_o = (state_reg == ST_RESP);
  assign bus.rsp_rdata_o = (state_reg == ST_RESP) ? rdata_reg : 32'h0;
  assign bus.rsp_err_o   = (state_reg == ST_RESP) && err_reg;

  assign mem_addr_o  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign mem_wdata_o = merged_reg;
  assign mem_we_o    = (state_reg == ST_WRITE) && !rst_i;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array reference model
// predicts every response, latency and memory write; a single compare
// process checks the response channel every cycle it is valid.
module tb_load_store_unit;

  localparam int DEPTH  = 2048;
  localparam int ADDR_W = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_we;

  load_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .bus         (bus),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata)
  );

  // Attached word memory with combinational read.
  logic [31:0] tbmem [0:DEPTH/4-1];
  int cyc = 0;
  int we_count = 0;
  int we_edge = 0;

  initial begin
    for (int i = 0; i < DEPTH/4; i++) tbmem[i] <= 32'h0;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      tbmem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
      we_count <= we_count + 1;
      we_edge  <= cyc + 1;
    end
    cyc <= cyc + 1;
  end

  assign mem_rdata = tbmem[mem_addr[ADDR_W-1:2]];

  // Reference model state: plain byte array.
  logic [7:0] refm [0:DEPTH-1];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {refm[a+3], refm[a+2], refm[a+1], refm[a]};
  endfunction

  // Behavioural model of one access: result, latency and number of writes.
  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, output bit [31:0] rd, output bit err,
                       output int lat, output int writes);
    int a, sz;
    bit legal;
    longint v;
    a  = int'(addr % DEPTH);
    sz = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    rd = 32'h0; err = 1'b0; writes = 0; lat = 1;
    if (!legal) err = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
    if (legal && (a % sz != 0)) err = 1'b1;
`else
    if (legal) a = a - (a % sz);
`endif
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (longint'(refm[a+i]) << (8*i));
      if (f3[2] == 1'b0 && sz < 4 && v >= (longint'(1) << (8*sz-1)))
        v = v - (longint'(1) << (8*sz));
      rd  = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < sz; i++) refm[a+i] = 8'((wd >> (8*i)) & 32'hFF);
      lat = (sz == 4) ? 2 : 3;
      writes = 1;
    end
  endtask

  // Expected response, published by the driver for the compare process.
  bit          exp_pending = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_err = 1'b0;

  // Compare process: every cycle a response is presented, it must match.
  always @(negedge clk) begin
    if (!rst_i && bus.rsp_valid_o) begin
      if (!exp_pending) begin
        chk("unexpected_rsp", {31'b0, bus.rsp_valid_o}, 32'h0);
      end else begin
        chk("rsp_rdata", bus.rsp_rdata_o, exp_rdata);
        chk("rsp_err", {31'b0, bus.rsp_err_o}, {31'b0, exp_err});
      end
      chk("req_ready_in_resp", {31'b0, bus.req_ready_o}, 32'h0);
    end
  end

  task automatic drive_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wd, output int acc_cyc);
    bit ok;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", {31'b0, bus.req_ready_o}, 32'h1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    // Garbage on the request bus must be ignored while busy.
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'($urandom_range(0, 1));
    bus.req_funct3_i = 3'($urandom_range(0, 7));
    bus.req_addr_i   = $urandom;
    bus.req_wdata_i  = $urandom;
  endtask

  task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                     input bit [31:0] wd, input int hold, input bit use_lit,
                     input bit [31:0] lit_rd, input bit lit_err);
    bit [31:0] m_rd;
    bit m_err, got;
    int m_lat, m_wr, lat, wc0, acc_cyc;
    model(we, f3, addr, wd, m_rd, m_err, m_lat, m_wr);
    if (use_lit) begin
      chk("model_rdata", m_rd, lit_rd);
      chk("model_err", {31'b0, m_err}, {31'b0, lit_err});
    end
    @(negedge clk);
    exp_rdata   = m_rd;
    exp_err     = m_err;
    exp_pending = 1'b1;
    bus.rsp_ready_i = (hold == 0);
    wc0 = we_count;
    drive_req(we, f3, addr, wd, acc_cyc);
    lat = 0; got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid_o) begin got = 1'b1; break; end
    end
    if (!got) chk("rsp_timeout", {31'b0, bus.rsp_valid_o}, 32'h1);
    chk("latency", 32'(lat), 32'(m_lat));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      bus.rsp_ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.rsp_ready_i = 1'b0;
    exp_pending = 1'b0;
    chk("rsp_drop", {31'b0, bus.rsp_valid_o}, 32'h0);
    chk("write_count", 32'(we_count - wc0), 32'(m_wr));
    if (m_wr != 0) chk("write_edge", 32'(we_edge - acc_cyc), 32'(m_lat - 1));
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             we, f3, addr, wd, m_rd, m_err, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready_o}, 32'h1);
    chk({tag, "_rsp_valid"}, {31'b0, bus.rsp_valid_o}, 32'h0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata_o, 32'h0);
    chk({tag, "_rsp_err"}, {31'b0, bus.rsp_err_o}, 32'h0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // SB interrupted by reset while in its write cycle: no write may land.
  task automatic reset_in_write(input bit [31:0] addr, input bit [31:0] wd);
    int wc0, acc_cyc;
    bit seen;
    @(negedge clk);
    exp_pending = 1'b0;
    bus.rsp_ready_i = 1'b1;
    wc0 = we_count;
    drive_req(1'b1, 3'd0, addr, wd, acc_cyc);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_we) begin seen = 1'b1; break; end
    end
    chk("we_seen_before_reset", {31'b0, mem_we}, 32'h1);
    rst_i = 1'b1;
    #1;
    chk("we_gated_by_reset", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    chk("rst_write_count", 32'(we_count - wc0), 32'h0);
    chk("rst_mem_word", tbmem[(addr % DEPTH) >> 2], ref_word(int'(addr % DEPTH) & ~3));
    $display("txn reset during SB write addr=%h seen_we=%0d", addr, seen);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) refm[i] = 8'h0;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    bus.rsp_ready_i  = 1'b0;
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_i = 1'b0;

    // Directed: sub-word loads from a preloaded word.
    txn(1, 3'd2, 32'h100, 32'h8899AABB, 0, 1, 32'h0, 0);
    txn(0, 3'd0, 32'h103, 32'h0, 0, 1, 32'hFFFFFF88, 0);
    txn(0, 3'd4, 32'h101, 32'h0, 0, 1, 32'h000000AA, 0);
    txn(0, 3'd1, 32'h102, 32'h0, 0, 1, 32'hFFFF8899, 0);
    txn(0, 3'd5, 32'h102, 32'h0, 0, 1, 32'h00008899, 0);
    // Read-modify-write stores.
    txn(1, 3'd0, 32'h102, 32'h00000055, 0, 1, 32'h0, 0);
    txn(0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h8855AABB, 0);
    txn(1, 3'd2, 32'h100, 32'h8899AABB, 0, 1, 32'h0, 0);
    txn(1, 3'd1, 32'h100, 32'h00001234, 0, 1, 32'h0, 0);
    txn(0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h88991234, 0);
    txn(1, 3'd2, 32'h104, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    txn(0, 3'd2, 32'h104, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    // Address wrap above ADDR_W.
    txn(0, 3'd2, 32'h100 + DEPTH, 32'h0, 0, 1, 32'h88991234, 0);
    // Misaligned accesses.
`ifdef LSU_ALIGN_CHECK_EN
    txn(0, 3'd2, 32'h101, 32'h0, 0, 1, 32'h0, 1);
    txn(1, 3'd1, 32'h103, 32'h00005678, 0, 1, 32'h0, 1);
    txn(0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h88991234, 0);
`else
    txn(0, 3'd2, 32'h101, 32'h0, 0, 1, 32'h88991234, 0);
    txn(1, 3'd1, 32'h103, 32'h00005678, 0, 1, 32'h0, 0);
    txn(0, 3'd2, 32'h100, 32'h0, 0, 1, 32'h56781234, 0);
`endif
    // Illegal funct3.
    txn(0, 3'd3, 32'h100, 32'h0, 0, 1, 32'h0, 1);
    txn(1, 3'd5, 32'h100, 32'hFFFFFFFF, 0, 1, 32'h0, 1);
    // Backpressure: response held for 5 cycles.
    txn(1, 3'd0, 32'h108, 32'h00000077, 5, 1, 32'h0, 0);
    // Reset during the write of a second SB.
    reset_in_write(32'h109, 32'h00000099);
    txn(0, 3'd2, 32'h108, 32'h0, 0, 1, 32'h00000077, 0);

    // Randomized traffic over a small window so accesses collide.
    for (int w = 0; w < 16; w++) txn(1, 3'd2, 32'h100 + 4*w, $urandom, 0, 0, 32'h0, 0);
    for (int n = 0; n < 150; n++) begin
      bit [31:0] ra;
      ra = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << ADDR_W);
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
          $urandom_range(0, 2), 0, 32'h0, 0);
    end
    for (int w = 0; w < 16; w++) chk("final_mem_word", tbmem[(32'h100 >> 2) + w], ref_word(32'h100 + 4*w));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle core's execute stage and the word-wide data `memory`. The memory exposes only whole-word writes and combinational word reads. This block therefore does three things:
- byte-lane extraction with sign/zero extension for LB/LH/LW/LBU/LHU;
- read-modify-write for SB/SH;
- alignment and funct3 legality checks.

It handles one request at a time over a valid/ready request channel and a valid/ready response channel.

## Interface
- `DEPTH`, 2048, memory size in bytes; must match the attached `memory`.
- `ADDR_W`, `$clog2(DEPTH)`, width of the memory byte address.
- `clk` input 1: the only clock; all state changes on its rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `req_valid_i` input 1: request present.
- `req_ready_o` output 1: unit can accept a request; high only in IDLE.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_funct3_i` input 3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr_i` input 32: byte address; bits above ADDR_W-1 are ignored (wrap).
- `req_wdata_i` input 32: store data; SB uses [7:0], SH uses [15:0].
- `rsp_valid_o` output 1: response present.
- `rsp_ready_i` input 1: consumer accepts the response.
- `rsp_rdata_o` output 32: extended load data; 0 for stores and errors.
- `rsp_err_o` output 1: misaligned address or illegal funct3; no memory write occurred.
- `mem_addr_o` output ADDR_W: byte address to `memory`, with [1:0] forced to 00.
- `mem_wdata_o` output 32: full word to write.
- `mem_we_o` output 1: word write enable.
- `mem_rdata_i` input 32: combinational read data from `memory`.

## Operation
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- On IDLE handshake (`req_valid_i && req_ready_o`), register we, funct3, addr and wdata, then classify:
  - illegal funct3 (loads 011/110/111; stores any value other than 000/001/010) → RESP, with err=1;
  - misaligned (half with addr[0]=1; word with addr[1:0]≠00) → RESP, with err=1;
  - load → LOAD;
  - SW → WRITE, with merged word = wdata;
  - SB/SH → MERGE.
- LOAD:
  - sample `mem_rdata_i`;
  - select the lane by addr[1:0] (little-endian; byte k = bits [8k+7:8k]; half = bytes {addr[1]*2+1, addr[1]*2});
  - sign-extend for LB/LH, zero-extend for LBU/LHU;
  - → RESP.
- MERGE: sample `mem_rdata_i`, replace the addressed byte or half with wdata[7:0] or wdata[15:0], keep the other lanes, → WRITE.
- WRITE: drive `mem_we_o`=1 and `mem_wdata_o`=merged word for exactly one cycle, → RESP.
- RESP: `rsp_valid_o`=1, with `rsp_rdata_o` and `rsp_err_o` stable. Stay until `rsp_ready_i`, then → IDLE.
- `mem_addr_o` always reflects the registered address, word-aligned.
- `mem_we_o` is 0 outside WRITE and is gated by `!rst_i`.

## Timing
- Reset state: IDLE. All outputs read 0 except `req_ready_o`, which reads 1.
- Cycle counts below run from the accept edge to the `rsp_valid_o` rising edge, with `rsp_ready_i`=1:
  - loads: 2 cycles;
  - SW: 2 cycles, with the memory write at the 2nd edge;
  - SB/SH: 3 cycles, with the write at the 3rd edge;
  - errors: 1 cycle.
- Throughput with `rsp_ready_i` held high: one request per latency+1 cycles. No request is accepted in RESP.
- Backpressure: while `rsp_ready_i`=0, the RESP outputs hold; no memory activity.
- Reset mid-operation: the next edge returns to IDLE, and the response is discarded. If `rst_i` is high during WRITE, no memory write occurs.
- `req_*` inputs are ignored while `req_ready_o`=0.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - misaligned accesses produce `rsp_err_o`=1 with no memory access.
- Not defined:
  - misalignment is not checked;
  - the address is forced to natural alignment (half: addr[0]←0; word: addr[1:0]←00) and the access proceeds normally;
  - `rsp_err_o` is raised only for illegal funct3.

## Structure
- `lsu_pkg` contains:
  - the state enum;
  - funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - a function returning the legality of `{we, funct3}`.
- Sub-module `lsu_lane`: purely combinational. It takes the word, addr[1:0] and funct3, and produces the extracted/extended load data and the merged store word.
- The FSM and registers live in `load_store_unit`.

## Test plan
- Word 0x100 preloaded with 0x8899AABB. LB at 0x103 → rdata 0xFFFFFF88. LBU at 0x101 → 0x000000AA. LH at 0x102 → 0xFFFF8899. Each response comes 2 cycles after accept.
- SB of 0x55 to 0x102, then LW at 0x100 → rdata 0x8855AABB. `mem_we_o` is high for exactly one cycle, 2 cycles after accept.
- SH of 0x1234 to 0x100, then LW at 0x100 → 0x88991234. SW of 0xDEADBEEF to 0x104, then LW at 0x104 → 0xDEADBEEF.
- Misaligned cases:
  - With `LSU_ALIGN_CHECK_EN`: LW at 0x101 → err=1 one cycle after accept, no write. SH at 0x103 → err=1 and word 0x100 unchanged.
  - Without it: LW at 0x101 reads word 0x100.
- Illegal funct3 011 load → err=1, rdata 0.
- SB issued with `rsp_ready_i`=0 → response held 5 cycles with `req_ready_o`=0. Assert `rst_i` during WRITE of a second SB → memory unchanged, and outputs are at reset values next cycle.
